// File: rtl/mem_port_arbiter_if.sv
// Bundle for the shared memory port: fetch (I) and load/store (D) requesters
// on one side, the single unified memory port on the other.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              i_stall;
  logic              d_stall;
  logic              grant_sel;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_ack, i_rdata, d_ack, d_rdata, i_stall, d_stall, grant_sel,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // requesters + memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_ack, i_rdata, d_ack, d_rdata, i_stall, d_stall, grant_sel,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the unified memory port. D wins ties unless
// it has won STARVE_LIMIT times in a row while I was waiting.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  state_t            state;
  mem_cmd_t          cmd;
  logic [3:0]        streak;
  logic              grant_q;
  logic              i_ack_q;
  logic              d_ack_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic i_elig, d_elig, starve, pick_i, pick_d;
  logic [3:0] streak_inc;

  // A held req is not eligible during its own ack cycle.
  assign i_elig = bus.i_req & ~i_ack_q;
  assign d_elig = bus.d_req & ~d_ack_q;
  assign starve = (streak == 4'(STARVE_LIMIT));
  assign pick_i = i_elig & (~d_elig | starve);
  assign pick_d = d_elig & ~pick_i;

  assign streak_inc = (streak == 4'hF) ? streak : streak + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd       <= '0;
      streak    <= '0;
      grant_q   <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_i) begin
            state     <= BUSY_I;
            cmd.req   <= 1'b1;
            cmd.we    <= 1'b0;
            cmd.addr  <= bus.i_addr;
            cmd.wdata <= '0;
            grant_q   <= 1'b0;
            streak    <= '0;
          end else if (pick_d) begin
            state     <= BUSY_D;
            cmd.req   <= 1'b1;
            cmd.we    <= bus.d_we;
            cmd.addr  <= bus.d_addr;
            cmd.wdata <= bus.d_wdata;
            grant_q   <= 1'b1;
            // Only count D wins that actually kept I waiting.
            streak    <= bus.i_req ? streak_inc : 4'd0;
          end
        end
        BUSY_I: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            cmd.req   <= 1'b0;
            i_rdata_q <= bus.mem_rdata;
            i_ack_q   <= 1'b1;
          end
        end
        BUSY_D: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            cmd.req   <= 1'b0;
            d_rdata_q <= bus.mem_rdata;
            d_ack_q   <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cmd.req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = cmd.req;
  assign bus.mem_we    = cmd.we;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wdata = cmd.wdata;
  assign bus.grant_sel = grant_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_stall   = bus.i_req & ~i_ack_q;
  assign bus.d_stall   = bus.d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and read data are
// queued at drive time and consumed by a negedge monitor.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } grant_t;

  grant_t      exp_grant[$];
  logic [63:0] exp_i[$];
  logic [63:0] exp_d[$];

  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    return a ^ 64'h0000_0000_DEAD_AEEF;
  endfunction

  task automatic push_grant(input logic sel, input logic we, input logic [63:0] a, input logic [63:0] wd);
    grant_t g;
    g.sel = sel; g.we = we; g.addr = a; g.wdata = wd;
    exp_grant.push_back(g);
  endtask

  // memory model: acks after mem_delay busy cycles
  int mem_delay = 0;
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!bus.mem_req) begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end else if (wcnt >= mem_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_fn(bus.mem_addr);
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // monitor
  initial begin
    logic        prev_req;
    logic [63:0] cur_addr, cur_wdata;
    grant_t      g;
    prev_req = 1'b0; cur_addr = '0; cur_wdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
      end else begin
        if (bus.i_ack && bus.d_ack) chk("dual_ack", 1, 0);
        if (bus.i_ack) begin
          if (exp_i.size() == 0) chk("i_ack_unexpected", 1, 0);
          else chk("i_rdata", bus.i_rdata, exp_i.pop_front());
        end
        if (bus.d_ack) begin
          if (exp_d.size() == 0) chk("d_ack_unexpected", 1, 0);
          else chk("d_rdata", bus.d_rdata, exp_d.pop_front());
        end
        if (bus.mem_req && !prev_req) begin
          if (exp_grant.size() == 0) chk("grant_unexpected", 1, 0);
          else begin
            g = exp_grant.pop_front();
            chk("grant_sel", bus.grant_sel, g.sel);
            chk("mem_we",    bus.mem_we,    g.we);
            chk("mem_addr",  bus.mem_addr,  g.addr);
            chk("mem_wdata", bus.mem_wdata, g.wdata);
            cur_addr  = g.addr;
            cur_wdata = g.wdata;
          end
        end else if (bus.mem_req) begin
          chk("mem_addr_hold",  bus.mem_addr,  cur_addr);
          chk("mem_wdata_hold", bus.mem_wdata, cur_wdata);
        end
        prev_req = bus.mem_req;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit is_d, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(is_d ? bus.d_ack : bus.i_ack) && k < budget);
    chk(is_d ? "d_ack_seen" : "i_ack_seen", is_d ? bus.d_ack : bus.i_ack, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    tick(3);
    @(negedge clk);
    chk("rst_mem_req",   bus.mem_req,   0);
    chk("rst_mem_we",    bus.mem_we,    0);
    chk("rst_grant_sel", bus.grant_sel, 0);
    chk("rst_i_ack",     bus.i_ack,     0);
    chk("rst_d_ack",     bus.d_ack,     0);
    chk("rst_mem_addr",  bus.mem_addr,  0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_i_rdata",   bus.i_rdata,   0);
    chk("rst_d_rdata",   bus.d_rdata,   0);
    tick(1);
    reset = 1'b0;
    tick(2);

    // I-only fetch, latency and stall shape
    push_grant(0, 0, 64'h1000, 0);
    exp_i.push_back(64'hDEADBEEF);
    bus.i_req = 1; bus.i_addr = 64'h1000;
    @(negedge clk);
    chk("t1_stall_n",   bus.i_stall, 1);
    chk("t1_req_n",     bus.mem_req, 0);
    @(negedge clk);
    chk("t1_stall_n1",  bus.i_stall, 1);
    chk("t1_req_n1",    bus.mem_req, 1);
    @(negedge clk);
    chk("t1_ack_n2",    bus.i_ack,   1);
    chk("t1_stall_n2",  bus.i_stall, 0);
    tick(1);
    bus.i_req = 0;
    tick(3);
    chk("t1_rdata_held", bus.i_rdata, 64'hDEADBEEF);

    // simultaneous I and D: D store first, I in d_ack's cycle
    push_grant(1, 1, 64'h2000, 64'h55);
    push_grant(0, 0, 64'h1008, 0);
    exp_d.push_back(mem_fn(64'h2000));
    exp_i.push_back(mem_fn(64'h1008));
    bus.i_req = 1; bus.i_addr = 64'h1008;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h2000; bus.d_wdata = 64'h55;
    wait_ack(1, 20);
    tick(1);
    bus.d_req = 0; bus.d_we = 0;
    @(negedge clk);
    chk("t2_i_ack_a1",  bus.i_ack,     0);
    chk("t2_req_a1",    bus.mem_req,   1);
    chk("t2_sel_a1",    bus.grant_sel, 0);
    @(negedge clk);
    chk("t2_i_ack_a2",  bus.i_ack,     1);
    tick(1);
    bus.i_req = 0;
    tick(2);

    // starvation guard: both re-request together each round; the loser
    // withdraws so the next round is again a two-way arbitration
    for (int r = 0; r < 10; r++) begin
      logic d_wins;
      d_wins = (r % 5) != 4;
      bus.i_req = 1; bus.i_addr = 64'h8000 + 64'(r * 8);
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h4000 + 64'(r * 8);
      bus.d_wdata = 64'(r);
      if (d_wins) begin
        push_grant(1, 0, 64'h4000 + 64'(r * 8), 64'(r));
        exp_d.push_back(mem_fn(64'h4000 + 64'(r * 8)));
      end else begin
        push_grant(0, 0, 64'h8000 + 64'(r * 8), 0);
        exp_i.push_back(mem_fn(64'h8000 + 64'(r * 8)));
      end
      tick(1);
      if (d_wins) bus.i_req = 0; else bus.d_req = 0;
      wait_ack(d_wins, 20);
      tick(1);
    end
    bus.i_req = 0; bus.d_req = 0;
    tick(2);

    // slow D load with address/req wiggling mid-transaction
    mem_delay = 5;
    push_grant(1, 0, 64'h3000, 64'h77);
    exp_d.push_back(mem_fn(64'h3000));
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h3000; bus.d_wdata = 64'h77;
    tick(2);
    bus.d_req = 0; bus.d_addr = 64'h3FF8; bus.d_wdata = 64'h99;
    tick(1);
    bus.d_req = 1;
    tick(1);
    bus.d_req = 0;
    wait_ack(1, 20);
    @(negedge clk);
    chk("t4_ack_single", bus.d_ack,   0);
    chk("t4_no_regrant", bus.mem_req, 0);
    chk("t4_rdata_held", bus.d_rdata, mem_fn(64'h3000));
    tick(1);

    // reset on the 2nd BUSY_I cycle abandons the fetch
    push_grant(0, 0, 64'h5000, 0);
    push_grant(0, 0, 64'h5000, 0);
    exp_i.push_back(mem_fn(64'h5000));
    bus.i_req = 1; bus.i_addr = 64'h5000;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_req_off",    bus.mem_req, 0);
    chk("t5_no_ack",     bus.i_ack,   0);
    chk("t5_i_rdata_clr", bus.i_rdata, 0);
    chk("t5_d_rdata_clr", bus.d_rdata, 0);
    wait_ack(0, 30);
    tick(1);
    bus.i_req = 0;
    mem_delay = 0;
    tick(2);

    // held i_req through its ack cycle: one dead cycle, then a new grant
    push_grant(0, 0, 64'h6000, 0);
    push_grant(0, 0, 64'h6000, 0);
    exp_i.push_back(mem_fn(64'h6000));
    exp_i.push_back(mem_fn(64'h6000));
    bus.i_req = 1; bus.i_addr = 64'h6000;
    wait_ack(0, 20);
    @(negedge clk);
    chk("t6_gap",    bus.mem_req, 0);
    @(negedge clk);
    chk("t6_regrant", bus.mem_req, 1);
    tick(1);
    bus.i_req = 0;
    wait_ack(0, 20);
    tick(3);

    chk("grants_left", 64'(exp_grant.size()), 0);
    chk("i_left",      64'(exp_i.size()),     0);
    chk("d_left",      64'(exp_d.size()),     0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 64-bit unified memory port between the instruction-fetch requester (I) and the load/store requester (D) of the pipelined core.
- Only one transaction is outstanding at a time.
- D has priority, with a starvation guard that protects I.
- Drives the 2:1 address/data select, a one-cycle completion pulse per requester, and stall indications for the hazard logic.

Parameters:
- ADDR_W, 64, width of the address buses
- DATA_W, 64, width of the read and write data buses
- STARVE_LIMIT, 4, maximum consecutive D grants while I is waiting before I is forced; range 1..15

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  ADDR_W  fetch address; stable while i_req is high
- i_ack  out  1  one-cycle pulse; fetch completed
- i_rdata  out  DATA_W  fetched word; valid when i_ack is high, held until the next I completion
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse; data access completed
- d_rdata  out  DATA_W  load data; valid when d_ack is high, held until the next D completion
- i_stall  out  1  i_req & ~i_ack (combinational)
- d_stall  out  1  d_req & ~d_ack (combinational)
- grant_sel  out  1  0 = I owns the port, 1 = D owns the port; drives the port 2:1 select
- mem_req  out  1  memory request, registered
- mem_we  out  1  registered write enable; always 0 for I
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data; 0 for I
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack is high
- mem_ack  in  1  memory completion; sampled only while mem_req is high

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. A 4-bit streak counter tracks consecutive D grants.
- Reset values: state IDLE, mem_req/mem_we/i_ack/d_ack/grant_sel = 0, mem_addr/mem_wdata/i_rdata/d_rdata = 0, streak = 0.
- Eligibility in IDLE: a requester is eligible if its req is high and its ack is not high in the same cycle. This prevents re-granting a held req during its own ack cycle.
- Arbitration in IDLE:
  - Only I eligible: grant I.
  - Only D eligible: grant D.
  - Both eligible: grant D unless streak == STARVE_LIMIT, in which case grant I.
- On grant at edge N:
  - Next state BUSY_x.
  - mem_req = 1; mem_addr/mem_we/mem_wdata loaded from the winner.
  - grant_sel set to the winner and held through BUSY.
- Streak update on grant:
  - D granted while i_req high: streak + 1, saturating at 15.
  - I granted: streak cleared.
  - D granted with i_req low: streak cleared.
- BUSY_x, mem_ack = 0: hold all mem_* outputs stable. There is no timeout.
- BUSY_x, mem_ack = 1 at edge M:
  - mem_req = 0; state IDLE.
  - x_rdata captured from mem_rdata; x_ack = 1 for the cycle after M only.
  - d_rdata is captured on stores as well.
- Latency: request seen in IDLE at cycle N; zero-wait memory acks at N+1; x_ack is high in cycle N+2. A new grant can occur in the ack cycle, so back-to-back requests from different requesters are spaced 2 cycles apart.
- Request dropped while BUSY: the transaction completes and the ack is still pulsed.
- Address or data changing while BUSY: has no effect, because the mem_* outputs are registered.
- reset during BUSY: synchronously returns to IDLE with mem_req = 0 at that edge. No ack is pulsed and the memory transaction is abandoned.
- Only one of i_ack/d_ack is ever high in a cycle. mem_req is never high in IDLE.

Test Plan:
- I-only fetch, addr 0x1000, mem_ack one cycle after mem_req, mem_rdata 0xDEADBEEF -> i_ack high at N+2, i_rdata = 0xDEADBEEF, grant_sel = 0, i_stall high for cycles N and N+1.
- i_req and d_req both rising at N, D store to 0x2000 with data 0x55 -> D granted first with mem_we = 1 and mem_wdata = 0x55; I granted in d_ack's cycle; i_ack arrives 2 cycles after d_ack.
- I and D continuously requesting, STARVE_LIMIT = 4, zero-wait memory -> grant order D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each I grant.
- D load with mem_ack delayed 5 cycles; d_addr and d_req toggled mid-transaction -> mem_addr unchanged for all 5 cycles; d_ack is a single pulse; d_rdata = mem_rdata at ack.
- reset asserted on the 2nd cycle of BUSY_I -> next cycle in IDLE with mem_req = 0, i_ack never pulsed; after reset is released with i_req still high, a fresh grant with mem_addr = i_addr.
- Held i_req during the i_ack cycle with d_req low -> no grant in the ack cycle; next grant one cycle later.
